sync_clk_ctrl: RTL

Parametrised multi-channel synchroniser that brings quasi-static control bits (padding disable, loopback, pause enables, etc.) from the host/register domain into the `clk_xgmii_tx` domain of the 10GE MAC. Each channel has a configurable-depth metastability chain, an optional stability filter that rejects short glitches, and registered rise/fall change pulses. A startup counter flags when outputs are trustworthy after reset. The block sits between the register file and the TX datapath control logic.

---
 rtl/xge_sync_pkg.sv | 15 +
 rtl/sync_ctrl_chan.sv | 86 ++++++++
 rtl/sync_clk_ctrl.sv | 72 +++++++
 3 files changed

// File: rtl/xge_sync_pkg.sv
// Shared constants and helpers for the XGMII TX control-bit synchroniser.
// The stability filter is built only when XGE_SYNC_STABLE_FILTER_EN is defined.
package xge_sync_pkg;

    localparam int SYNC_STAGES_MIN   = 2;
    localparam int STABLE_CYCLES_MIN = 1;

    // Width of a counter that must hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_ctrl_chan.sv
// One synchroniser channel: metastability chain, optional stability filter
// (XGE_SYNC_STABLE_FILTER_EN) and registered rise/fall pulses.
module sync_ctrl_chan
    import xge_sync_pkg::*;
#(
    parameter int   SYNC_STAGES   = 2,
    parameter int   STABLE_CYCLES = 4,
    parameter logic RESET_BIT     = 1'b0
) (
    input  logic clk_xgmii_tx,
    input  logic reset_xgmii_tx,
    input  logic din,
    input  logic pulse_en,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain_q, chain_d;
    logic                   out_q, out_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s_n;
    logic                   update;

    assign s_n = chain_q[SYNC_STAGES-1];

`ifdef XGE_SYNC_STABLE_FILTER_EN
    localparam int             CW       = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // A return to the accepted value mid-count discards the partial count.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        cnt_d  = cnt_q;
        update = 1'b0;
        if (s_n == out_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            update = 1'b1;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_xgmii_tx) begin
        if (reset_xgmii_tx) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign update = (s_n != out_q);
`endif

    always_comb begin
        chain_d = {chain_q[SYNC_STAGES-2:0], din};
        out_d   = update ? s_n : out_q;
        rise_d  = update & pulse_en & s_n;
        fall_d  = update & pulse_en & ~s_n;
    end

    always_ff @(posedge clk_xgmii_tx) begin
        if (reset_xgmii_tx) begin
            chain_q <= {SYNC_STAGES{RESET_BIT}};
            out_q   <= RESET_BIT;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values, like real hardware.
            chain_q <= chain_d;
            out_q   <= out_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign dout = out_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/sync_clk_ctrl.sv
// Multi-channel control-bit synchroniser into clk_xgmii_tx with startup-valid flag.
// Define XGE_SYNC_STABLE_FILTER_EN to build the per-channel stability filter.
module sync_clk_ctrl
    import xge_sync_pkg::*;
#(
    parameter int                DWIDTH        = 1,
    parameter int                SYNC_STAGES   = 2,
    parameter int                STABLE_CYCLES = 4,
    parameter logic [DWIDTH-1:0] RESET_VAL     = '0
) (
    input  logic              clk_xgmii_tx,
    input  logic              reset_xgmii_tx,
    input  logic [DWIDTH-1:0] in,
    output logic [DWIDTH-1:0] out,
    output logic [DWIDTH-1:0] rise,
    output logic [DWIDTH-1:0] fall,
    output logic              sync_valid
);

`ifdef XGE_SYNC_STABLE_FILTER_EN
    localparam int FILTER_CYCLES = STABLE_CYCLES;
`else
    localparam int FILTER_CYCLES = 1;
`endif
    localparam int START_MAX = SYNC_STAGES + FILTER_CYCLES;
    localparam int SW        = $clog2(START_MAX + 1);

    if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync_stages
        $error("sync_clk_ctrl: SYNC_STAGES must be at least %0d", SYNC_STAGES_MIN);
    end
    if (STABLE_CYCLES < STABLE_CYCLES_MIN) begin : g_bad_stable_cycles
        $error("sync_clk_ctrl: STABLE_CYCLES must be at least %0d", STABLE_CYCLES_MIN);
    end

    logic [SW-1:0] start_cnt_q, start_cnt_d;
    logic          sync_valid_q, sync_valid_d;

    // Saturating edge count since reset; valid once every chain and filter has flushed.
    always_comb begin
        start_cnt_d  = (start_cnt_q == SW'(START_MAX)) ? start_cnt_q : start_cnt_q + SW'(1);
        sync_valid_d = (start_cnt_d == SW'(START_MAX));
    end

    always_ff @(posedge clk_xgmii_tx) begin
        if (reset_xgmii_tx) begin
            start_cnt_q  <= '0;
            sync_valid_q <= 1'b0;
        end else begin
            start_cnt_q  <= start_cnt_d;
            sync_valid_q <= sync_valid_d;
        end
    end

    assign sync_valid = sync_valid_q;

    for (genvar i = 0; i < DWIDTH; i++) begin : g_chan
        sync_ctrl_chan #(
            .SYNC_STAGES   (SYNC_STAGES),
            .STABLE_CYCLES (STABLE_CYCLES),
            .RESET_BIT     (RESET_VAL[i])
        ) u_chan (
            .clk_xgmii_tx   (clk_xgmii_tx),
            .reset_xgmii_tx (reset_xgmii_tx),
            .din            (in[i]),
            .pulse_en       (sync_valid_q),
            .dout           (out[i]),
            .rise           (rise[i]),
            .fall           (fall[i])
        );
    end

endmodule
